// File: rtl/lane_object_row.sv
// Purpose : one traffic/log lane of NUM_OBJ moving sprites with per-pixel hit test and sprite-RAM address.
// Latency : is_obj/hit_any/read_addr one Clk after DrawX/DrawY; wrap_pulse one Clk after the wrapping frame edge.
// Backpressure : none; free-running pixel pipeline. Optional LANE_COLLIDE_EN adds frog ports and the collide flag.
module lane_object_row #(
   parameter int NUM_OBJ   = 4,
   parameter int OBJ_W     = 56,
   parameter int OBJ_H     = 28,
   parameter int X_MIN     = 124,
   parameter int X_MAX     = 544,
   parameter int FRAC_BITS = 4,
   parameter int ADDR_W    = 19
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  frame_clk_rising_edge,
   input  logic                  load_level,
   input  logic                  pause,
   input  logic                  direction,
   input  logic [9:0]            speed,
   input  logic [9:0]            row_y,
   input  logic [NUM_OBJ-1:0]    obj_en,
   input  logic [NUM_OBJ*10-1:0] offsets,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
`ifdef LANE_COLLIDE_EN
   input  logic [9:0]            frog_x,
   input  logic [9:0]            frog_y,
   input  logic [5:0]            frog_sz,
`endif
   output logic [NUM_OBJ-1:0]    is_obj,
   output logic                  hit_any,
   output logic [ADDR_W-1:0]     read_addr,
   output logic [NUM_OBJ-1:0]    wrap_pulse,
   output logic                  collide
);

   localparam int PW = 12 + FRAC_BITS;

   localparam logic signed [11:0] W12     = 12'(OBJ_W);
   localparam logic signed [11:0] XMIN12  = 12'(X_MIN);
   localparam logic signed [11:0] XMAX12  = 12'(X_MAX);
   localparam logic signed [11:0] XRWRAP  = 12'(X_MIN - OBJ_W);
   localparam logic signed [11:0] XLWRAP  = 12'(X_MAX + 1);
   localparam logic signed [12:0] W13     = 13'(OBJ_W);
   localparam logic signed [10:0] H11     = 11'(OBJ_H);
   localparam logic [ADDR_W-1:0]  OBJ_WA  = ADDR_W'(OBJ_W);
   localparam logic [ADDR_W-1:0]  ONE_A   = ADDR_W'(1);

   // Sprite position state: integer pixel X plus fractional part.
   logic signed [11:0]          x_q [NUM_OBJ];
   logic [FRAC_BITS-1:0]        f_q [NUM_OBJ];
   logic signed [11:0]          x_n [NUM_OBJ];
   logic [FRAC_BITS-1:0]        f_n [NUM_OBJ];
   logic signed [PW-1:0]        pos_sum [NUM_OBJ];
   logic [NUM_OBJ-1:0]          wrap_n;
   logic signed [PW-1:0]        step;
   logic                        load_q;
   logic                        reload;
   logic                        move;

   logic signed [12:0]          dx [NUM_OBJ];
   logic signed [10:0]          dy;
   logic [NUM_OBJ-1:0]          hit;
   logic signed [12:0]          dx_sel;
   logic [ADDR_W-1:0]           dxa;
   logic [ADDR_W-1:0]           dya;
   logic [ADDR_W-1:0]           addr_n;

   assign step   = $signed({{(PW-10){1'b0}}, speed});
   assign reload = Reset | load_q;
   // A raw load strobe also blocks motion so a coincident frame edge never moves the lane.
   assign move   = frame_clk_rising_edge & ~pause & (speed != 10'd0) & ~load_level;

   // Delay the level strobe one cycle so offsets and row_y have settled before reload.
   always_ff @(posedge Clk) begin
      if (Reset) load_q <= 1'b0;
      else       load_q <= load_level;
   end

   // Next position per sprite: wrap (checked on the current position) replaces the step.
   always_comb begin
      wrap_n = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         x_n[i]     = x_q[i];
         f_n[i]     = f_q[i];
         pos_sum[i] = direction ? ($signed({x_q[i], f_q[i]}) + step)
                                : ($signed({x_q[i], f_q[i]}) - step);
         if (move && obj_en[i]) begin
            if (!direction && (x_q[i] + W12 <= XMIN12)) begin
               x_n[i]    = XLWRAP;
               f_n[i]    = '0;
               wrap_n[i] = 1'b1;
            end else if (direction && (x_q[i] > XMAX12)) begin
               x_n[i]    = XRWRAP;
               f_n[i]    = '0;
               wrap_n[i] = 1'b1;
            end else begin
               x_n[i] = pos_sum[i][PW-1:FRAC_BITS];
               f_n[i] = pos_sum[i][FRAC_BITS-1:0];
            end
         end
      end
   end

   // Pixel hit test against every sprite box; the lowest-index hit supplies the RAM address.
   always_comb begin
      dy     = $signed({1'b0, DrawY}) - $signed({1'b0, row_y});
      dx_sel = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         dx[i]  = $signed({3'b000, DrawX}) - $signed({x_q[i][11], x_q[i]});
         hit[i] = obj_en[i] && (dx[i] >= 0) && (dx[i] < W13) && (dy >= 0) && (dy < H11);
      end
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         if (hit[i]) dx_sel = dx[i];
      end
      dxa = ADDR_W'(dx_sel);
      dya = ADDR_W'(dy);
      if (!(|hit))       addr_n = '0;
      else if (direction) addr_n = OBJ_WA * (dya + ONE_A) - ONE_A - dxa;
      else                addr_n = OBJ_WA * dya + dxa;
   end

   // Position update and registered pixel outputs; reload restores start offsets and clears outputs.
   always_ff @(posedge Clk) begin
      if (reload) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            x_q[i] <= XMIN12 + $signed({2'b00, offsets[10*i +: 10]});
            f_q[i] <= '0;
         end
         is_obj     <= '0;
         hit_any    <= 1'b0;
         read_addr  <= '0;
         wrap_pulse <= '0;
      end else begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            x_q[i] <= x_n[i];
            f_q[i] <= f_n[i];
         end
         is_obj     <= hit;
         hit_any    <= |hit;
         read_addr  <= addr_n;
         wrap_pulse <= wrap_n;
      end
   end

`ifdef LANE_COLLIDE_EN
   logic [NUM_OBJ-1:0] ovl;
   logic signed [12:0] fx, fy, fs, ry;

   // Strict box overlap between each enabled sprite and the frog.
   always_comb begin
      fx = $signed({3'b000, frog_x});
      fy = $signed({3'b000, frog_y});
      fs = $signed({7'b0000000, frog_sz});
      ry = $signed({3'b000, row_y});
      for (int i = 0; i < NUM_OBJ; i++) begin
         ovl[i] = obj_en[i]
                  && ($signed({x_q[i][11], x_q[i]}) < fx + fs)
                  && (fx < $signed({x_q[i][11], x_q[i]}) + W13)
                  && (ry < fy + fs)
                  && (fy < ry + 13'(OBJ_H));
      end
   end

   // Collision flag is sampled once per frame and held until the next edge.
   always_ff @(posedge Clk) begin
      if (reload)                                    collide <= 1'b0;
      else if (frame_clk_rising_edge && !load_level) collide <= |ovl;
   end
`else
   assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_lane_object_row.sv
// Purpose : directed bench for lane_object_row with a pixel-unit behavioural model and per-cycle compare.
// Latency : model mirrors the one-cycle output registration; literal probes pin the model.
// Backpressure : none.
module tb_lane_object_row;

   localparam int NUM_OBJ = 4;
   localparam int OBJ_W   = 56;
   localparam int OBJ_H   = 28;
   localparam int X_MIN   = 124;
   localparam int X_MAX   = 544;
   localparam int ADDR_W  = 19;

   logic                  Clk = 1'b0;
   logic                  Reset;
   logic                  frame_clk_rising_edge;
   logic                  load_level;
   logic                  pause;
   logic                  direction;
   logic [9:0]            speed;
   logic [9:0]            row_y;
   logic [NUM_OBJ-1:0]    obj_en;
   logic [NUM_OBJ*10-1:0] offsets;
   logic [9:0]            DrawX;
   logic [9:0]            DrawY;
`ifdef LANE_COLLIDE_EN
   logic [9:0]            frog_x;
   logic [9:0]            frog_y;
   logic [5:0]            frog_sz;
`endif
   logic [NUM_OBJ-1:0]    is_obj;
   logic                  hit_any;
   logic [ADDR_W-1:0]     read_addr;
   logic [NUM_OBJ-1:0]    wrap_pulse;
   logic                  collide;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #10 Clk = ~Clk;

   lane_object_row dut (
      .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame_clk_rising_edge),
      .load_level(load_level), .pause(pause), .direction(direction), .speed(speed),
      .row_y(row_y), .obj_en(obj_en), .offsets(offsets), .DrawX(DrawX), .DrawY(DrawY),
`ifdef LANE_COLLIDE_EN
      .frog_x(frog_x), .frog_y(frog_y), .frog_sz(frog_sz),
`endif
      .is_obj(is_obj), .hit_any(hit_any), .read_addr(read_addr),
      .wrap_pulse(wrap_pulse), .collide(collide)
   );

   // ---------------- behavioural model (positions in 1/16 pixel units) ----------------
   int         pos [NUM_OBJ];
   bit         m_load_q = 1'b0;
   logic [3:0] e_is;
   logic       e_hit;
   int         e_addr;
   logic [3:0] e_wrap;
   logic       e_col;
   int         m_x, m_dx, m_dy;
   bit         m_found;

   always @(posedge Clk) begin
      if (Reset || m_load_q) begin
         for (int i = 0; i < NUM_OBJ; i++) pos[i] = (X_MIN + int'(offsets[10*i +: 10])) * 16;
         e_is = '0; e_hit = 1'b0; e_addr = 0; e_wrap = '0; e_col = 1'b0;
      end else begin
         e_is = '0; e_addr = 0; m_found = 1'b0;
         m_dy = int'(DrawY) - int'(row_y);
         for (int i = 0; i < NUM_OBJ; i++) begin
            m_x  = pos[i] >>> 4;
            m_dx = int'(DrawX) - m_x;
            if (obj_en[i] && m_dx >= 0 && m_dx < OBJ_W && m_dy >= 0 && m_dy < OBJ_H) begin
               e_is[i] = 1'b1;
               if (!m_found) begin
                  m_found = 1'b1;
                  e_addr  = direction ? OBJ_W * (m_dy + 1) - 1 - m_dx : OBJ_W * m_dy + m_dx;
               end
            end
         end
         e_hit = |e_is;
`ifdef LANE_COLLIDE_EN
         if (frame_clk_rising_edge && !load_level) begin
            e_col = 1'b0;
            for (int i = 0; i < NUM_OBJ; i++) begin
               m_x = pos[i] >>> 4;
               if (obj_en[i] && m_x < int'(frog_x) + int'(frog_sz) && int'(frog_x) < m_x + OBJ_W &&
                   int'(row_y) < int'(frog_y) + int'(frog_sz) && int'(frog_y) < int'(row_y) + OBJ_H)
                  e_col = 1'b1;
            end
         end
`else
         e_col = 1'b0;
`endif
         e_wrap = '0;
         if (frame_clk_rising_edge && !pause && speed != 10'd0 && !load_level) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
               if (obj_en[i]) begin
                  m_x = pos[i] >>> 4;
                  if (!direction && m_x + OBJ_W <= X_MIN) begin
                     pos[i] = (X_MAX + 1) * 16; e_wrap[i] = 1'b1;
                  end else if (direction && m_x > X_MAX) begin
                     pos[i] = (X_MIN - OBJ_W) * 16; e_wrap[i] = 1'b1;
                  end else begin
                     pos[i] = direction ? pos[i] + int'(speed) : pos[i] - int'(speed);
                  end
               end
            end
         end
      end
      m_load_q = Reset ? 1'b0 : load_level;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare of every output against the model.
   always @(negedge Clk) begin
      if (chk_en) begin
         chk("cyc_is_obj",     32'(is_obj),     32'(e_is));
         chk("cyc_hit_any",    32'(hit_any),    32'(e_hit));
         chk("cyc_read_addr",  32'(read_addr),  32'(e_addr));
         chk("cyc_wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
         chk("cyc_collide",    32'(collide),    32'(e_col));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic probe(input int x, input int y, input logic d);
      DrawX = 10'(x); DrawY = 10'(y); direction = d;
      tick();
      @(negedge Clk);
   endtask

   task automatic frames(input int n, output int wcnt);
      wcnt = 0;
      repeat (n) begin
         frame_clk_rising_edge = 1'b1;
         tick();
         @(negedge Clk); wcnt += int'(wrap_pulse[0]);
         frame_clk_rising_edge = 1'b0;
         tick();
         @(negedge Clk); wcnt += int'(wrap_pulse[0]);
      end
   endtask

   int wc;

   initial begin
      Reset = 1'b1; frame_clk_rising_edge = 1'b0; load_level = 1'b0; pause = 1'b0;
      direction = 1'b0; speed = 10'd0; row_y = 10'd384; obj_en = 4'hF;
      offsets = {10'd420, 10'd280, 10'd140, 10'd0};
      DrawX = 10'd0; DrawY = 10'd0;
`ifdef LANE_COLLIDE_EN
      frog_x = 10'd0; frog_y = 10'd0; frog_sz = 6'd0;
`endif
      @(posedge Clk); #1; chk_en = 1'b1;
      tick();
      @(negedge Clk);
      chk("rst_is_obj", 32'(is_obj), 0);
      chk("rst_read_addr", 32'(read_addr), 0);
      chk("rst_wrap", 32'(wrap_pulse), 0);
      chk("rst_collide", 32'(collide), 0);
      Reset = 1'b0;
      chk("model_x0", pos[0] >>> 4, 124);
      chk("model_x1", pos[1] >>> 4, 264);
      chk("model_x2", pos[2] >>> 4, 404);
      chk("model_x3", pos[3] >>> 4, 544);

      probe(127, 386, 1'b0);
      chk("reset_pix_is", 32'(is_obj), 4'b0001);
      chk("reset_pix_addr", 32'(read_addr), 115);
      probe(544, 384, 1'b0);
      chk("sprite3_is", 32'(is_obj), 4'b1000);
      chk("sprite3_addr", 32'(read_addr), 0);

      // Left at 2.0 px for 10 frames.
      speed = 10'h020; direction = 1'b0;
      frames(10, wc);
      chk("left10_wrap0", wc, 0);
      chk("model_left10", pos[0] >>> 4, 104);
      probe(104, 384, 1'b0);
      chk("left10_edge_is", 32'(is_obj), 4'b0001);
      chk("left10_edge_addr", 32'(read_addr), 0);
      probe(103, 384, 1'b0);
      chk("left10_outside", 32'(hit_any), 0);

      // Right at 0.5 px for 4 frames, then paused.
      speed = 10'h008; direction = 1'b1;
      frames(4, wc);
      chk("model_half4", pos[0] >>> 4, 106);
      probe(109, 386, 1'b0);
      chk("half_addr_dir0", 32'(read_addr), 115);
      probe(109, 386, 1'b1);
      chk("half_addr_dir1", 32'(read_addr), 164);
      pause = 1'b1;
      frames(3, wc);
      pause = 1'b0;
      probe(109, 386, 1'b1);
      chk("pause_addr", 32'(read_addr), 164);
      probe(105, 384, 1'b1);
      chk("pause_left_of_x0", 32'(is_obj[0]), 0);

      // Zero speed: nothing moves, no wrap.
      speed = 10'd0;
      frames(2, wc);
      chk("zero_speed_wrap", wc, 0);
      chk("model_zero_speed", pos[0] >>> 4, 106);

      // Fast left then fast right to force wraps on sprite 0.
      speed = 10'h3F0; direction = 1'b0;
      frames(3, wc);
      chk("left_wrap_pulses", wc, 1);
      chk("model_left_wrap", pos[0] >>> 4, 482);
      direction = 1'b1;
      frames(3, wc);
      chk("right_wrap_pulses", wc, 1);
      chk("model_right_wrap", pos[0] >>> 4, 131);

      // Load coincident with a frame edge; overlapping sprites 0 and 1.
      offsets = {10'd420, 10'd280, 10'd10, 10'd0};
      load_level = 1'b1; frame_clk_rising_edge = 1'b1;
      tick();
      load_level = 1'b0; frame_clk_rising_edge = 1'b0;
      tick(); tick();
      chk("model_load_x0", pos[0] >>> 4, 124);
      chk("model_load_x1", pos[1] >>> 4, 134);
      probe(139, 384, 1'b0);
      chk("overlap_is", 32'(is_obj), 4'b0011);
      chk("overlap_addr_dir0", 32'(read_addr), 15);
      probe(139, 384, 1'b1);
      chk("overlap_addr_dir1", 32'(read_addr), 40);

      // Disabled sprite 2 never hits and does not move.
      obj_en = 4'b1011;
      probe(404, 384, 1'b0);
      chk("dis_is_obj", 32'(is_obj), 0);
      chk("dis_hit_any", 32'(hit_any), 0);
      speed = 10'h020; direction = 1'b0;
      frames(3, wc);
      chk("model_dis_hold", pos[2] >>> 4, 404);
      probe(404, 384, 1'b0);
      chk("dis_still_no_hit", 32'(hit_any), 0);

`ifdef LANE_COLLIDE_EN
      frog_x = 10'(pos[1] >>> 4); frog_y = 10'd390; frog_sz = 6'd20;
      frames(1, wc);
      chk("collide_set", 32'(collide), 1);
      load_level = 1'b1; tick(); load_level = 1'b0; tick();
      @(negedge Clk);
      chk("collide_clear", 32'(collide), 0);
`endif

      tick(); tick();
      @(negedge Clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
